// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order result queue draining onto the register-file and accumulator write ports,
// with per-register pending-write flags for decode hazard stalls.
module regfile_writeback #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic                       res_to_acc,
  input  logic [ADDR_W-1:0]          res_dest,
  input  logic [DATA_W-1:0]          res_data,
  input  logic                       flush,
  input  logic                       wb_stall,
  output logic                       write_enable,
  output logic [ADDR_W-1:0]          write_addr,
  output logic [DATA_W-1:0]          write_data,
  output logic                       acc_write_enable,
  output logic [DATA_W-1:0]          acc_in,
  output logic [(1<<ADDR_W)-1:0]     pend_reg,
  output logic                       pend_acc,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 issued_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic              acc_q  [DEPTH];
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        issued_q, issued_d;
  logic              push, issue;
  assign res_ready = (count_q < CW'(DEPTH)) & !flush;
  assign push      = res_valid & res_ready;
  assign issue     = (count_q != '0) & !wb_stall & !flush;
  assign write_enable     = issue & !acc_q[head_q];
  assign acc_write_enable = issue & acc_q[head_q];
  assign write_addr = write_enable ? dest_q[head_q] : '0;
  assign write_data = write_enable ? data_q[head_q] : '0;
  assign acc_in     = acc_write_enable ? data_q[head_q] : '0;
  assign count      = count_q;
  assign issued_cnt = issued_q;
  always_comb begin
    head_d   = flush ? '0 : (issue ? head_q + PW'(1) : head_q);
    tail_d   = flush ? '0 : (push ? tail_q + PW'(1) : tail_q);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(issue);
    issued_d = (issue && issued_q != 8'hFF) ? issued_q + 8'd1 : issued_q;
  end
  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pend_reg = '0;
    pend_acc = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - head_q} < count_q) begin
        if (acc_q[i]) pend_acc = 1'b1;
        else pend_reg[dest_q[i]] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      issued_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        acc_q[i]  <= 1'b0;
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      issued_q <= issued_d;
      if (push) begin
        acc_q[tail_q]  <= res_to_acc;
        dest_q[tail_q] <= res_dest;
        data_q[tail_q] <= res_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed stimulus with a write scoreboard checked by an independent strobe monitor.
module tb_regfile_writeback;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       res_valid = 0, res_to_acc = 0, flush = 0, wb_stall = 0;
  logic [1:0] res_dest = 0;
  logic [3:0] res_data = 0;
  logic       res_ready, write_enable, acc_write_enable, pend_acc;
  logic [1:0] write_addr, count;
  logic [3:0] write_data, acc_in, pend_reg;
  logic [7:0] issued_cnt;
  typedef struct packed {logic a; logic [1:0] d; logic [3:0] v;} wr_t;
  wr_t sb[$];
  int checks = 0, errors = 0;
  regfile_writeback dut (
    .clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_to_acc(res_to_acc), .res_dest(res_dest), .res_data(res_data),
    .flush(flush), .wb_stall(wb_stall), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .acc_write_enable(acc_write_enable), .acc_in(acc_in),
    .pend_reg(pend_reg), .pend_acc(pend_acc), .count(count), .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic a, input logic [1:0] d, input logic [3:0] v);
    int n = 0;
    res_valid = 1; res_to_acc = a; res_dest = d; res_data = v;
    while (!res_ready && n < 50) begin
      step();
      n++;
    end
    if (!res_ready) chk("push_timeout", 0, 1);
    else sb.push_back('{a, a ? 2'b00 : d, v});
    step();
    res_valid = 0;
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (write_enable && acc_write_enable) chk("dual_strobe", 1, 0);
      if (!write_enable) chk("idle_reg_bus", {write_addr, write_data}, 0);
      if (!acc_write_enable) chk("idle_acc_bus", acc_in, 0);
      if (write_enable || acc_write_enable) begin
        if (sb.size() == 0) chk("unexpected_strobe", {acc_write_enable, write_addr, write_data}, 0);
        else chk("wb_entry", {acc_write_enable, acc_write_enable ? 2'b00 : write_addr,
                              acc_write_enable ? acc_in : write_data}, sb.pop_front());
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_ready", res_ready, 1);
    chk("rst_strobes", {write_enable, acc_write_enable}, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_pend", {pend_reg, pend_acc}, 0);
    reset_n = 1;
    step();
    // register write
    push(0, 2'b01, 4'b1010);
    chk("reg_we", write_enable, 1);
    chk("reg_pend", pend_reg, 4'b0010);
    chk("reg_count", count, 1);
    step();
    chk("reg_after_we", write_enable, 0);
    chk("reg_after_pend", pend_reg, 0);
    chk("reg_issued", issued_cnt, 1);
    // accumulator write
    push(1, 2'b00, 4'b1100);
    chk("acc_we", acc_write_enable, 1);
    chk("acc_reg_we", write_enable, 0);
    chk("acc_pend", pend_acc, 1);
    step();
    chk("acc_after_pend", pend_acc, 0);
    chk("acc_issued", issued_cnt, 2);
    // stall and fill
    wb_stall = 1;
    push(0, 2'b10, 4'b0011);
    push(0, 2'b11, 4'b1111);
    res_valid = 1; res_to_acc = 0; res_dest = 2'b00; res_data = 4'b0110;
    chk("full_count", count, 2);
    chk("full_ready", res_ready, 0);
    chk("full_pend", pend_reg, 4'b1100);
    chk("stall_strobes", {write_enable, acc_write_enable}, 0);
    step();
    chk("held_count", count, 2);
    wb_stall = 0;
    push(0, 2'b00, 4'b0110);
    step(); step();
    chk("stall_issued", issued_cnt, 5);
    chk("stall_drained", count, 0);
    // flush with simultaneous valid
    wb_stall = 1;
    push(0, 2'b00, 4'b0101);
    push(1, 2'b00, 4'b0110);
    chk("pre_flush_count", count, 2);
    flush = 1; res_valid = 1; res_to_acc = 0; res_dest = 2'b11; res_data = 4'b1001;
    chk("flush_ready", res_ready, 0);
    chk("flush_strobes", {write_enable, acc_write_enable}, 0);
    sb.delete();
    step();
    flush = 0; res_valid = 0; wb_stall = 0;
    chk("flush_count", count, 0);
    chk("flush_pend", {pend_reg, pend_acc}, 0);
    step(); step();
    chk("flush_issued", issued_cnt, 5);
    // wrap and saturation
    for (int i = 0; i < 300; i++) push(i[0], 2'b00, i[3:0]);
    step(); step();
    chk("sat_issued", issued_cnt, 255);
    chk("sat_count", count, 0);
    // asynchronous reset with entries queued
    wb_stall = 1;
    push(0, 2'b10, 4'b0001);
    push(0, 2'b01, 4'b0010);
    chk("pre_rst_pend", pend_reg, 4'b0110);
    #2 reset_n = 0;
    #1;
    sb.delete();
    chk("arst_count", count, 0);
    chk("arst_pend", {pend_reg, pend_acc}, 0);
    chk("arst_strobes", {write_enable, acc_write_enable}, 0);
    chk("arst_issued", issued_cnt, 0);
    step();
    reset_n = 1; wb_stall = 0;
    chk("arst_ready", res_ready, 1);
    step(); step();
    chk("final_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
